// File: rtl/noc_pkg.sv
// Shared NOC definitions: command codes, idle byte, byte payload type, length decode.
package noc_pkg;

  localparam logic [2:0] CMD_READ      = 3'b001;
  localparam logic [2:0] CMD_WRITE     = 3'b010;
  localparam logic [2:0] CMD_WRITE_ACK = 3'b100;
  localparam logic [2:0] CMD_READ_RESP = 3'b011;

  localparam logic [7:0] IDLE_BYTE = 8'h00;

  typedef struct packed {
    logic       ctl;
    logic [7:0] data;
  } noc_byte_t;

  localparam noc_byte_t IDLE_WORD = '{ctl: 1'b1, data: IDLE_BYTE};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_t;

  // Address bytes that follow a command byte
  function automatic logic [2:0] alen_of(input logic [2:0] cmd);
    logic [2:0] len;
    len = 3'd0;
    if (cmd == CMD_READ || cmd == CMD_WRITE) len = 3'd4;
    return len;
  endfunction

  // Data bytes carried by a command, 2^size for data-bearing commands
  function automatic logic [3:0] dlen_of(input logic [2:0] cmd, input logic [1:0] size);
    logic [3:0] len;
    len = 4'd0;
    if (cmd == CMD_WRITE || cmd == CMD_READ_RESP) len = 4'd1 << size;
    return len;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan ptr+1 .. ptr+N and keep the first hit
  always_comb begin
    int unsigned c;
    c      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      c = (32'(ptr) + k) % N;
      if (!any && req[IW'(c)]) begin
        any               = 1'b1;
        onehot[IW'(c)]    = 1'b1;
        idx               = IW'(c);
      end
    end
  end

endmodule

// File: rtl/noc_resp_arb.sv
// Packet-atomic round-robin arbiter for the device-to-NOC byte channel.
module noc_resp_arb
  import noc_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_ctl,
  input  logic [NREQ*8-1:0]        req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     noc_from_dev_ctl,
  output logic [7:0]               noc_from_dev_data,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     underrun,
  output logic                     proto_err,
  input  logic                     clr_err,
  output logic [CNT_W-1:0]         pkt_count
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_t     state;
  logic [IW-1:0]  rr_ptr;
  noc_byte_t      out_q;

  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic [IW-1:0]   sel;
  logic            sel_valid;
  logic            sel_ctl;
  logic            sel_last;
  logic [7:0]      sel_data;

  logic            set_proto;
  logic            set_under;

  // Only command bytes compete for the channel while idle
  assign cand = (state == ST_IDLE) ? (req_valid & req_ctl) : '0;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req    (cand),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Mux the byte of the requester being served (new winner or current owner)
  always_comb begin
    sel       = (state == ST_IDLE) ? pick_idx : grant_id;
    sel_valid = 1'b0;
    sel_ctl   = 1'b0;
    sel_last  = 1'b0;
    sel_data  = IDLE_BYTE;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel == IW'(i)) begin
        sel_valid = req_valid[i];
        sel_ctl   = req_ctl[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  // Ready: winner in IDLE, owner's own valid in SEND
  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE) begin
      req_ready = pick_oh;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant_id == IW'(i)) req_ready[i] = req_valid[i];
      end
    end
  end

  // Sticky-flag set events
  always_comb begin
    set_proto = 1'b0;
    set_under = 1'b0;
    if (state == ST_IDLE) begin
      set_proto = |(req_valid & ~req_ctl);
    end else begin
      set_proto = sel_valid & sel_ctl;
      set_under = ~sel_valid;
    end
  end

  // Arbiter state, output register, flags and packet counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= IW'(NREQ - 1);
      out_q     <= IDLE_WORD;
      busy      <= 1'b0;
      grant_id  <= '0;
      underrun  <= 1'b0;
      proto_err <= 1'b0;
      pkt_count <= '0;
    end else begin
      underrun  <= (underrun  & ~clr_err) | set_under;
      proto_err <= (proto_err & ~clr_err) | set_proto;
      out_q     <= IDLE_WORD;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            out_q    <= '{ctl: 1'b1, data: sel_data};
            grant_id <= pick_idx;
            if (sel_last) begin
              rr_ptr    <= pick_idx;
              pkt_count <= pkt_count + CNT_W'(1);
            end else begin
              state <= ST_SEND;
              busy  <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (sel_valid) begin
            // Command bytes inside a message are forwarded as data
            out_q <= '{ctl: 1'b0, data: sel_data};
            if (sel_last) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              rr_ptr    <= grant_id;
              pkt_count <= pkt_count + CNT_W'(1);
            end
          end else begin
            // Owner vanished: the idle byte terminates the message on the NOC
            state  <= ST_IDLE;
            busy   <= 1'b0;
            rr_ptr <= grant_id;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign noc_from_dev_ctl  = out_q.ctl;
  assign noc_from_dev_data = out_q.data;

endmodule
